// File: rtl/spi_byte_engine_if.sv
// spi_byte_engine_if
// Groups the command/status handshake and the SPI pins of spi_byte_engine.
//   master : ctrl-decode side plus the slave devices (drives commands and MISO)
//   slave  : the shift engine (drives MOSI/SCK/nSS and status)
// Signals:
//   CMD_VALID  one-cycle start pulse      CMD_DATA  byte to send, MSB first
//   CMD_SEL    nSS pattern, active-low    DESEL     one-cycle release of nSS
//   STAT_CLR   one-cycle OVERRUN clear    MISO      [0]/[1] per slave, [2] when none selected
//   MOSI/SCK   serial data / clock (mode 0)   nSS   slave selects, active-low
//   BUSY       transfer in progress       RX_DATA   last received byte
//   RX_VALID   one-cycle RX_DATA update   OVERRUN   sticky command-dropped flag
interface spi_byte_engine_if;
  logic       CMD_VALID;
  logic [7:0] CMD_DATA;
  logic [1:0] CMD_SEL;
  logic       DESEL;
  logic       STAT_CLR;
  logic [2:0] MISO;
  logic       MOSI;
  logic       SCK;
  logic [1:0] nSS;
  logic       BUSY;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       OVERRUN;

  modport master (
    output CMD_VALID, CMD_DATA, CMD_SEL, DESEL, STAT_CLR, MISO,
    input  MOSI, SCK, nSS, BUSY, RX_DATA, RX_VALID, OVERRUN
  );

  modport slave (
    input  CMD_VALID, CMD_DATA, CMD_SEL, DESEL, STAT_CLR, MISO,
    output MOSI, SCK, nSS, BUSY, RX_DATA, RX_VALID, OVERRUN
  );
endinterface

// File: rtl/spi_byte_engine.sv
// spi_byte_engine
// One-command-per-byte SPI master (mode 0, MSB first). A CMD_VALID pulse loads
// a byte and a slave-select pattern; the engine then produces 8 SCK pulses of
// 2*CLKDIV CLK cycles each, shifting MOSI out and MISO in, and returns the
// received byte with a one-cycle RX_VALID. nSS stays asserted after a byte so
// back-to-back bytes to the same device keep it selected; DESEL releases it.
// Ports:
//   CLK  clock
//   RST  asynchronous reset, active-high
//   bus  spi_byte_engine_if.slave (commands, status, SPI pins)
// Parameter:
//   CLKDIV  SCK half-period in CLK cycles, 1..15
// Optional build macro:
//   SPI_TXQ_EN  adds a one-deep command holding register so a command issued
//               while busy is chained seamlessly after the current byte.
module spi_byte_engine #(
  parameter int CLKDIV = 2
) (
  input logic             CLK,
  input logic             RST,
  spi_byte_engine_if.slave bus
);

  localparam logic [3:0] LP_DIV_LAST = 4'(CLKDIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t     r_state;
  logic [3:0] r_div;
  logic [2:0] r_bit;
  logic [6:0] r_tx;        // remaining tx bits; bit 7 goes straight to MOSI on load
  logic [7:0] r_rx;
  logic       r_mosi;
  logic       r_sck;
  logic [1:0] r_nss;
  logic       r_busy;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_overrun;
  logic       r_desel_pend;

  logic       w_misox;
  logic       w_phase_end;
  logic       w_busy_st;
  logic       w_xfer_end;
  logic       w_drop;
  logic       w_chain;
  logic       w_load;
  logic [7:0] w_ld_data;
  logic [1:0] w_ld_sel;

  // MISO[2] is the line read when no slave is selected.
  assign w_misox = (bus.MISO[0] & ~r_nss[0]) |
                   (bus.MISO[1] & ~r_nss[1]) |
                   (bus.MISO[2] & r_nss[0] & r_nss[1]);

  assign w_phase_end = (r_div == LP_DIV_LAST);
  assign w_busy_st   = (r_state != IDLE);
  assign w_xfer_end  = (r_state == HIGH) && w_phase_end && (r_bit == 3'd7);

`ifdef SPI_TXQ_EN
  logic       r_q_full;
  logic [7:0] r_q_data;
  logic [1:0] r_q_sel;
  logic       w_q_push;

  // A command arriving exactly on the ending edge with the holder empty is
  // loaded directly instead of passing through the holder.
  assign w_q_push  = bus.CMD_VALID && w_busy_st && !r_q_full && !w_xfer_end;
  assign w_drop    = bus.CMD_VALID && w_busy_st && r_q_full;
  assign w_chain   = w_xfer_end && (r_q_full || bus.CMD_VALID);
  assign w_ld_data = r_q_full ? r_q_data : bus.CMD_DATA;
  assign w_ld_sel  = r_q_full ? r_q_sel  : bus.CMD_SEL;
`else
  assign w_drop    = bus.CMD_VALID && w_busy_st;
  assign w_chain   = 1'b0;
  assign w_ld_data = bus.CMD_DATA;
  assign w_ld_sel  = bus.CMD_SEL;
`endif

  // Start of a byte: from IDLE, or chained on the edge that ends the previous one.
  assign w_load = (bus.CMD_VALID && !w_busy_st) || w_chain;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_div        <= 4'd0;
      r_bit        <= 3'd0;
      r_mosi       <= 1'b0;
      r_sck        <= 1'b0;
      r_nss        <= 2'b11;
      r_busy       <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_overrun    <= 1'b0;
      r_desel_pend <= 1'b0;
`ifdef SPI_TXQ_EN
      r_q_full     <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;

      // Set has priority over clear.
      if (w_drop)
        r_overrun <= 1'b1;
      else if (bus.STAT_CLR)
        r_overrun <= 1'b0;

      if (bus.DESEL && w_busy_st)
        r_desel_pend <= 1'b1;

      case (r_state)
        IDLE: begin
          // A simultaneous command takes precedence over DESEL.
          if (!bus.CMD_VALID && bus.DESEL)
            r_nss <= 2'b11;
        end
        LOW: begin
          if (w_phase_end) begin
            r_sck   <= 1'b1;
            r_div   <= 4'd0;
            r_state <= HIGH;
          end else begin
            r_div <= r_div + 4'd1;
          end
        end
        HIGH: begin
          if (w_phase_end) begin
            r_sck <= 1'b0;
            r_div <= 4'd0;
            if (r_bit != 3'd7) begin
              r_mosi  <= r_tx[6];
              r_bit   <= r_bit + 3'd1;
              r_state <= LOW;
            end else begin
              r_rx_data    <= r_rx;
              r_rx_valid   <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= IDLE;
              r_desel_pend <= 1'b0;
              // A chained byte keeps its own select; a deselect is dropped.
              if (!w_chain && (r_desel_pend || bus.DESEL))
                r_nss <= 2'b11;
            end
          end else begin
            r_div <= r_div + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Loading overrides the end-of-byte return to IDLE.
      if (w_load) begin
        r_nss        <= w_ld_sel;
        r_mosi       <= w_ld_data[7];
        r_sck        <= 1'b0;
        r_busy       <= 1'b1;
        r_bit        <= 3'd0;
        r_div        <= 4'd0;
        r_desel_pend <= 1'b0;
        r_state      <= LOW;
      end

`ifdef SPI_TXQ_EN
      if (w_q_push)
        r_q_full <= 1'b1;
      else if (w_chain)
        r_q_full <= 1'b0;
`endif
    end
  end

  // Shift and holding data registers carry no reset; they are always loaded
  // before being used.
  always_ff @(posedge CLK) begin
    if (w_load)
      r_tx <= w_ld_data[6:0];
    else if ((r_state == HIGH) && w_phase_end && (r_bit != 3'd7))
      r_tx <= {r_tx[5:0], 1'b0};

    // MISO is sampled on the edge that raises SCK.
    if ((r_state == LOW) && w_phase_end)
      r_rx <= {r_rx[6:0], w_misox};

`ifdef SPI_TXQ_EN
    if (w_q_push) begin
      r_q_data <= bus.CMD_DATA;
      r_q_sel  <= bus.CMD_SEL;
    end
`endif
  end

  assign bus.MOSI     = r_mosi;
  assign bus.SCK      = r_sck;
  assign bus.nSS      = r_nss;
  assign bus.BUSY     = r_busy;
  assign bus.RX_DATA  = r_rx_data;
  assign bus.RX_VALID = r_rx_valid;
  assign bus.OVERRUN  = r_overrun;

endmodule

// File: doc/spi_byte_engine.md
Name: spi_byte_engine

Overview:
Hardware SPI shift engine for the extension board. It replaces per-bit software toggling of MOSI/SCK/nSS through ctrl codes with one command per byte. The ctrl-decode logic issues a one-cycle command carrying the TX byte and the slave select. The engine drives nSS, SCK and MOSI, samples MISO, and returns the RX byte for the Gigatron bus read mux.

Parameters:
CLKDIV, 2, SCK half-period in CLK cycles; legal range 1..15 (CLKDIV=1 gives SCK = CLK/2).

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
CMD_VALID  in  1  one-cycle pulse: start byte transfer
CMD_DATA  in  8  byte to transmit, MSB first
CMD_SEL  in  2  nSS pattern for this transfer, active-low
DESEL  in  1  one-cycle pulse: release nSS to 2'b11
STAT_CLR  in  1  one-cycle pulse: clear OVERRUN
MISO  in  3  MISO[0]/[1] from selected slaves; MISO[2] when none selected
MOSI  out  1  serial data out
SCK  out  1  serial clock, mode 0 (idle low)
nSS  out  2  slave selects, active-low
BUSY  out  1  transfer in progress
RX_DATA  out  8  last received byte
RX_VALID  out  1  one-cycle pulse: RX_DATA updated
OVERRUN  out  1  sticky: command dropped

Behaviour:
- Reset values (asynchronous on RST): MOSI=0, SCK=0, nSS=2'b11, BUSY=0, RX_DATA=8'h00, RX_VALID=0, OVERRUN=0. Also: state=IDLE, bit count=0, divider=0, deselect-pending=0. A reset during a transfer aborts it immediately; no RX_VALID is produced.
- misox = (MISO[0]&!nSS[0]) | (MISO[1]&!nSS[1]) | (MISO[2]&nSS[0]&nSS[1]). Evaluated on the current nSS value.
- States: IDLE, LOW, HIGH.
- IDLE + CMD_VALID at edge E0:
  - nSS<=CMD_SEL, MOSI<=CMD_DATA[7], tx shift<=CMD_DATA, SCK=0.
  - BUSY<=1, bit count<=0, divider<=0, state<=LOW.
- LOW, divider counts 0..CLKDIV-1. At the edge ending the phase:
  - SCK<=1; rx shift<={rx[6:0],misox}; divider<=0; state<=HIGH.
- HIGH, same divider. At the edge ending the phase, SCK<=0, then:
  - Bit count<7: MOSI<=next tx bit; bit count+1; state<=LOW.
  - Bit count=7: RX_DATA<=rx shift incl. last bit; RX_VALID<=1 for one cycle; BUSY<=0; state<=IDLE.
- Latency: BUSY is high for exactly 16*CLKDIV cycles after E0. RX_VALID asserts in the cycle BUSY falls. MOSI is stable for a full SCK period around each rising edge.
- nSS persists after the transfer; consecutive bytes to one device keep it low.
- CMD_SEL=2'b11 is legal: a transfer with no device selected, sampling MISO[2].
- CMD_VALID while BUSY (no queue): command dropped, OVERRUN<=1.
- STAT_CLR clears OVERRUN. If STAT_CLR and an overrun occur in the same cycle, set wins.
- DESEL while IDLE: nSS<=2'b11 next edge.
- DESEL while BUSY: deselect-pending<=1. nSS<=2'b11 at the edge that ends the transfer.
- DESEL and CMD_VALID in the same IDLE cycle: command wins; DESEL is ignored.
- CMD_VALID in the cycle BUSY falls is seen as IDLE and accepted. A pending deselect is then discarded; the new CMD_SEL applies.

Optional Feature:
SPI_TXQ_EN
- Defined: adds a one-deep command holding register (data+sel) with a full flag.
  - CMD_VALID while BUSY and queue empty: command is queued, no overrun.
  - CMD_VALID while BUSY and queue full: command dropped, OVERRUN<=1.
  - At the transfer-ending edge with queue full: the queued command is loaded directly into LOW (same actions as E0). BUSY stays high, no gap cycle, nSS updated to the queued sel. RX_VALID still pulses for the finished byte.
  - A pending DESEL is applied only if the queue is empty at the ending edge; otherwise it is discarded.
  - RST clears the queue.
- Undefined: no holding register; any CMD_VALID while BUSY sets OVERRUN.

Test Plan:
1. Reset: assert RST mid-simulation, no clock edge -> all outputs at reset values (nSS=2'b11, SCK=0, BUSY=0) immediately.
2. CLKDIV=2; CMD_DATA=8'hA5, CMD_SEL=2'b10; model slave on MISO[0] returns 8'h3C:
   - MOSI sampled at SCK rises reads 1,0,1,0,0,1,0,1.
   - BUSY high 32 cycles, 8 SCK pulses.
   - RX_DATA=8'h3C with RX_VALID pulse of 1 cycle; nSS stays 2'b10 afterwards.
3. Without SPI_TXQ_EN: second CMD_VALID at cycle 10 of a transfer -> OVERRUN=1, RX_DATA = first byte only. STAT_CLR -> OVERRUN=0; STAT_CLR+overrun in the same cycle -> OVERRUN=1.
4. DESEL at cycle 5 of a transfer -> nSS stays 2'b10 until the ending edge, then 2'b11. DESEL and CMD_VALID in the same idle cycle -> nSS=CMD_SEL.
5. With SPI_TXQ_EN, sends of 8'h01 then 8'h02 (second while busy), sel 2'b01, then a third while busy:
   - BUSY high 64 cycles continuous, nSS=2'b01 throughout.
   - Two RX_VALID pulses 32 cycles apart; OVERRUN=0.
   - Third command with the queue full -> OVERRUN=1.
6. RST pulse during bit 3, then a new command 8'hFF with CMD_SEL=2'b11 and MISO[2]=1 -> no stale RX_VALID; RX_DATA=8'hFF after 32 cycles.
